// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared pipeline-record types and forwarding-select encodings for the hazard unit
// and the EX-stage operand muxes.
package hazard_fwd_ctrl_pkg;

    localparam int unsigned REG_W = 5;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic             use_rs1;
        logic             use_rs2;
        logic [REG_W-1:0] rd;
        logic             reg_write;
        logic             mem_read;
    } pipe_rec_t;

    localparam pipe_rec_t BUBBLE_REC = '0;

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_select.sv
// One operand's forwarding select: EX/MEM producer beats MEM/WB producer, x0 never forwarded.
module fwd_select
    import hazard_fwd_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] src,
    input  logic             src_use,
    input  pipe_rec_t        mem_r,
    input  pipe_rec_t        wb_r,
    output logic [1:0]       sel
);

    logic unused_fields;
    assign unused_fields = ^{mem_r.rs1, mem_r.rs2, mem_r.use_rs1, mem_r.use_rs2, mem_r.mem_read,
                             wb_r.rs1, wb_r.rs2, wb_r.use_rs1, wb_r.use_rs2, wb_r.mem_read};

    always_comb begin
        sel = FWD_NONE;
        if (src_use) begin
            if (mem_r.valid && mem_r.reg_write && (mem_r.rd != '0) && (mem_r.rd == src)) begin
                sel = FWD_MEM;
            end else if (wb_r.valid && wb_r.reg_write && (wb_r.rd != '0) && (wb_r.rd == src)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Forwarding, load-use stall and branch flush control with shadow ID/EX, EX/MEM, MEM/WB records.
// Optional performance counters are built only when HAZ_PERF_EN is defined.
module hazard_fwd_ctrl
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  ex_branch_taken,
    input  logic                  mem_stall,
    output logic [1:0]            forwardA,
    output logic [1:0]            forwardB,
    output logic                  pc_hold,
    output logic                  id_ex_bubble,
    output logic                  if_id_flush,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
);

    pipe_rec_t ex_q, ex_d;
    pipe_rec_t mem_q, mem_d;
    pipe_rec_t wb_q, wb_d;
    pipe_rec_t id_rec;
    logic      load_use;

    always_comb begin
        id_rec           = BUBBLE_REC;
        id_rec.valid     = id_valid;
        id_rec.rs1       = REG_W'(id_rs1);
        id_rec.rs2       = REG_W'(id_rs2);
        id_rec.use_rs1   = id_use_rs1;
        id_rec.use_rs2   = id_use_rs2;
        id_rec.rd        = REG_W'(id_rd);
        id_rec.reg_write = id_reg_write;
        id_rec.mem_read  = id_mem_read;
    end

    always_comb begin
        load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && id_valid &&
                   ((id_use_rs1 && (id_rec.rs1 == ex_q.rd)) ||
                    (id_use_rs2 && (id_rec.rs2 == ex_q.rd)));
    end

    // mem_stall freezes everything; otherwise a branch or load-use replaces the ID record with a bubble
    always_comb begin
        ex_d         = ex_q;
        mem_d        = mem_q;
        wb_d         = wb_q;
        pc_hold      = 1'b0;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        if (mem_stall) begin
            pc_hold = 1'b1;
        end else begin
            wb_d  = mem_q;
            mem_d = ex_q;
            if (ex_branch_taken) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                ex_d         = BUBBLE_REC;
            end else if (load_use) begin
                pc_hold      = 1'b1;
                id_ex_bubble = 1'b1;
                ex_d         = BUBBLE_REC;
            end else begin
                ex_d = id_rec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q  <= BUBBLE_REC;
            mem_q <= BUBBLE_REC;
            wb_q  <= BUBBLE_REC;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    fwd_select u_fwd_a (
        .src     (ex_q.rs1),
        .src_use (ex_q.valid & ex_q.use_rs1),
        .mem_r   (mem_q),
        .wb_r    (wb_q),
        .sel     (forwardA)
    );

    fwd_select u_fwd_b (
        .src     (ex_q.rs2),
        .src_use (ex_q.valid & ex_q.use_rs2),
        .mem_r   (mem_q),
        .wb_r    (wb_q),
        .sel     (forwardB)
    );

`ifdef HAZ_PERF_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (mem_stall || (load_use && !ex_branch_taken)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
        if (!mem_stall && ex_branch_taken) begin
            flush_count_d = flush_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed and randomized checks of hazard_fwd_ctrl against an instruction-history reference model.
module tb_hazard_fwd_ctrl;

    localparam int RW = 5;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid;
    logic [RW-1:0] id_rs1, id_rs2, id_rd;
    logic          id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
    logic          ex_branch_taken, mem_stall;
    logic [1:0]    forwardA, forwardB;
    logic          pc_hold, id_ex_bubble, if_id_flush;
    logic [CW-1:0] stall_cycles, flush_count;

    always #5 clk = ~clk;

    hazard_fwd_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .id_rd           (id_rd),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .mem_stall       (mem_stall),
        .forwardA        (forwardA),
        .forwardB        (forwardB),
        .pc_hold         (pc_hold),
        .id_ex_bubble    (id_ex_bubble),
        .if_id_flush     (if_id_flush),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
    );

    int errors = 0;
    int checks = 0;

    // Instruction history: index 0 = in EX, 1 = in MEM, 2 = in WB.
    typedef struct {
        bit v;
        int rs1, rs2;
        bit u1, u2;
        int rd;
        bit rw, mr;
    } ins_t;

    ins_t          hist[3];
    logic [CW-1:0] m_stall, m_flush;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [CW-1:0] es, input logic [CW-1:0] ef);
`ifdef HAZ_PERF_EN
        chk({tag, "_stall_cnt"}, 32'(stall_cycles), 32'(es));
        chk({tag, "_flush_cnt"}, 32'(flush_count), 32'(ef));
`else
        chk({tag, "_stall_cnt"}, 32'(stall_cycles), 32'(0 * es));
        chk({tag, "_flush_cnt"}, 32'(flush_count), 32'(0 * ef));
`endif
    endtask

    function automatic ins_t id_ins();
        ins_t r;
        r.v  = id_valid;
        r.rs1 = int'(id_rs1);
        r.rs2 = int'(id_rs2);
        r.u1 = id_use_rs1;
        r.u2 = id_use_rs2;
        r.rd = int'(id_rd);
        r.rw = id_reg_write;
        r.mr = id_mem_read;
        return r;
    endfunction

    // Nearest older writer of src supplies the operand; x0 and missing writers mean register file.
    function automatic logic [1:0] ref_fwd(input int src, input bit u);
        if (!hist[0].v || !u) return 2'b00;
        for (int k = 1; k <= 2; k++) begin
            if (hist[k].v && hist[k].rw && hist[k].rd != 0 && hist[k].rd == src)
                return (k == 1) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    function automatic bit ref_lu();
        ins_t id = id_ins();
        if (!(hist[0].v && hist[0].mr && hist[0].rd != 0 && id.v)) return 1'b0;
        return (id.u1 && id.rs1 == hist[0].rd) || (id.u2 && id.rs2 == hist[0].rd);
    endfunction

    task automatic half();
        bit lu;
        @(negedge clk);
        lu = ref_lu();
        chk("fwdA", 32'(forwardA), 32'(ref_fwd(hist[0].rs1, hist[0].u1)));
        chk("fwdB", 32'(forwardB), 32'(ref_fwd(hist[0].rs2, hist[0].u2)));
        chk("pc_hold", 32'(pc_hold), 32'(mem_stall || (!ex_branch_taken && lu)));
        chk("bubble", 32'(id_ex_bubble), 32'(!mem_stall && (ex_branch_taken || lu)));
        chk("flush", 32'(if_id_flush), 32'(!mem_stall && ex_branch_taken));
        chk_cnt("model", m_stall, m_flush);
    endtask

    task automatic fin();
        bit lu;
        @(posedge clk);
        lu = ref_lu();
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) hist[k] = '{default: 0};
            m_stall = '0;
            m_flush = '0;
        end else begin
            if (mem_stall || (lu && !ex_branch_taken)) m_stall = m_stall + 1;
            if (!mem_stall && ex_branch_taken) m_flush = m_flush + 1;
            if (!mem_stall) begin
                hist[2] = hist[1];
                hist[1] = hist[0];
                if (ex_branch_taken || lu) hist[0] = '{default: 0};
                else hist[0] = id_ins();
            end
        end
        #1;
    endtask

    task automatic step();
        half();
        fin();
    endtask

    task automatic set_id(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                          input int rd, input bit rw, input bit mr);
        id_valid     = v;
        id_rs1       = rs1[RW-1:0];
        id_use_rs1   = u1;
        id_rs2       = rs2[RW-1:0];
        id_use_rs2   = u2;
        id_rd        = rd[RW-1:0];
        id_reg_write = rw;
        id_mem_read  = mr;
    endtask

    task automatic nop();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic exp_ctl(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                           input logic ph, input logic bub, input logic fl);
        chk({tag, "_fwdA"}, 32'(forwardA), 32'(fa));
        chk({tag, "_fwdB"}, 32'(forwardB), 32'(fb));
        chk({tag, "_pc_hold"}, 32'(pc_hold), 32'(ph));
        chk({tag, "_bubble"}, 32'(id_ex_bubble), 32'(bub));
        chk({tag, "_flush"}, 32'(if_id_flush), 32'(fl));
    endtask

    initial begin
        for (int k = 0; k < 3; k++) hist[k] = '{default: 0};
        m_stall = '0;
        m_flush = '0;
        rst_n = 1'b0;
        ex_branch_taken = 1'b0;
        mem_stall = 1'b0;
        nop();
        fin();
        fin();
        rst_n = 1'b1;
        half();
        exp_ctl("reset", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        chk_cnt("reset", 0, 0);
        fin();

        // ADD x1 then ADD x3,x1,x2 back to back
        set_id(1, 2, 1, 4, 1, 1, 1, 0); step();
        set_id(1, 1, 1, 2, 1, 3, 1, 0); step();
        nop(); half();
        exp_ctl("b2b", 2'b10, 2'b00, 1'b0, 1'b0, 1'b0);
        fin();

        // one independent instruction in between
        set_id(1, 2, 1, 4, 1, 1, 1, 0); step();
        set_id(1, 10, 1, 11, 1, 9, 1, 0); step();
        set_id(1, 1, 1, 2, 1, 3, 1, 0); step();
        nop(); half();
        exp_ctl("one_between", 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
        fin();

        // x5 written by both MEM and WB, read on rs2
        set_id(1, 1, 1, 2, 1, 5, 1, 0); step();
        set_id(1, 3, 1, 4, 1, 5, 1, 0); step();
        set_id(1, 6, 1, 5, 1, 12, 1, 0); step();
        nop(); half();
        exp_ctl("x5_prio", 2'b00, 2'b10, 1'b0, 1'b0, 1'b0);
        fin();

        // x0 is never forwarded
        set_id(1, 1, 1, 2, 1, 0, 1, 0); step();
        set_id(1, 0, 1, 0, 1, 13, 1, 0); step();
        nop(); half();
        exp_ctl("x0", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        fin();

        // LW x7 followed by ADD x8,x7,x9
        set_id(1, 2, 1, 0, 0, 7, 1, 1); step();
        set_id(1, 7, 1, 9, 1, 8, 1, 0); half();
        exp_ctl("lu_stall", 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
        fin();
        half();
        exp_ctl("lu_release", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        fin();
        nop(); half();
        exp_ctl("lu_fwd", 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
        chk_cnt("lu_fwd", 1, 0);
        fin();

        // taken branch coinciding with load-use
        set_id(1, 2, 1, 0, 0, 7, 1, 1); step();
        set_id(1, 7, 1, 9, 1, 8, 1, 0);
        ex_branch_taken = 1'b1;
        half();
        exp_ctl("br_lu", 2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
        fin();
        ex_branch_taken = 1'b0;

        // mem_stall held for 3 cycles during a load-use
        set_id(1, 2, 1, 0, 0, 7, 1, 1); half();
        chk_cnt("after_br", 1, 1);
        fin();
        set_id(1, 7, 1, 9, 1, 8, 1, 0);
        mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            half();
            exp_ctl("ms_hold", 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
            fin();
        end
        mem_stall = 1'b0;
        half();
        exp_ctl("lu_after_ms", 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
        chk_cnt("lu_after_ms", 4, 1);
        fin();

        // reset during an active load-use
        set_id(1, 2, 1, 0, 0, 7, 1, 1); step();
        set_id(1, 7, 1, 9, 1, 8, 1, 0);
        rst_n = 1'b0;
        step();
        half();
        exp_ctl("rst_mid", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        chk_cnt("rst_mid", 0, 0);
        fin();
        rst_n = 1'b1;

        // random traffic over a small register range to provoke collisions
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            set_id($urandom_range(0, 3) != 0,
                   int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                   int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                   int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 2) == 0);
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            mem_stall = ($urandom_range(0, 5) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
